// File: rtl/dmem_responder_if.sv
// Request/response channel between the load/store datapath (master) and the
// multi-cycle data memory (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic [1:0]  req_type;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_write, req_type, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_write, req_type, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory with wait states and a held response.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned accesses instead of force-aligning them.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic           write_q;
    logic [1:0]     type_q;
    logic [31:0]    rdata_q;
    logic           err_q;

    logic [31:0]    mem_q [DEPTH_WORDS];

    logic [AW-1:0]  idx;
    logic [31:0]    word_rd;
    logic [3:0]     bmask;
    logic [31:0]    bitmask;
    logic [31:0]    wdata_rep;
    logic [31:0]    rdata_c;
    logic           err_c;
    logic           accept;

    assign accept = (state_q == StIdle) && bus.req_valid;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) state_d = StAccess;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StAccess: state_d = StResp;
            StResp:   if (bus.resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.resp_valid = (state_q == StResp);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
    end

    // Request capture and registered response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            type_q  <= 2'b00;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr[AW+1:0];
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
                type_q  <= bus.req_type;
            end
            if (state_q == StAccess) begin
                rdata_q <= rdata_c;
                err_q   <= err_c;
            end
        end
    end

    // Lane decode; halfword/word lanes ignore the low address bits when not flagged
    always_comb begin
        idx     = addr_q[AW+1:2];
        word_rd = mem_q[idx];
`ifdef DMEM_MISALIGN_ERR_EN
        err_c = ((type_q == 2'b01) && addr_q[0]) || (type_q[1] && (addr_q[1:0] != 2'b00));
`else
        err_c = 1'b0;
`endif
        unique case (type_q)
            2'b00: begin
                bmask     = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
                rdata_c   = {24'h0, word_rd[8*addr_q[1:0] +: 8]};
            end
            2'b01: begin
                bmask     = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
                rdata_c   = {16'h0, (addr_q[1] ? word_rd[31:16] : word_rd[15:0])};
            end
            default: begin
                bmask     = 4'b1111;
                wdata_rep = wdata_q;
                rdata_c   = word_rd;
            end
        endcase
        for (int b = 0; b < 4; b++) bitmask[8*b +: 8] = {8{bmask[b]}};
        if (write_q || err_c) rdata_c = '0;
    end

    // Storage is never reset; a store commits only on its ACCESS edge
    always_ff @(posedge clock) begin
        if ((state_q == StAccess) && write_q && !err_c) begin
            mem_q[idx] <= (word_rd & ~bitmask) | (wdata_rep & bitmask);
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_dmem_responder;
    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Latency counts the accepting edge as edge 1, so WAIT_CYCLES=2 gives 4.
    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                        input logic [1:0] ty, output logic [31:0] rd, output logic er,
                        output int lat);
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_write  = wr;
        bus.req_type   = ty;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clock);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        for (int e = 2; e <= 40; e++) begin
            @(posedge clock);
            #1;
            if (bus.resp_valid) begin
                lat = e;
                rd  = bus.resp_rdata;
                er  = bus.resp_err;
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_write  = 1'b0;
        bus.req_type   = 2'b00;
        bus.resp_ready = 1'b0;
        #12;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        n_tests++; if (bus.resp_rdata !== 32'h0) begin n_fail++;
            $display("FAIL reset_rdata got %h want 0", bus.resp_rdata); end
        n_tests++; if (bus.resp_err !== 1'b0) begin n_fail++;
            $display("FAIL reset_err got %b want 0", bus.resp_err); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        xfer(32'h10, 32'hDEADBEEF, 1'b1, 2'b10, rd, er, lat);
        n_tests++; if (rd !== 32'h0 || lat != 4) begin n_fail++;
            $display("FAIL word_store rdata %h lat %0d want 0 lat 4", rd, lat); end
        xfer(32'h10, 32'h0, 1'b0, 2'b10, rd, er, lat);
        n_tests++; if (rd !== 32'hDEADBEEF || lat != 4) begin n_fail++;
            $display("FAIL word_load rdata %h lat %0d want deadbeef lat 4", rd, lat); end
        n_tests++; if (er !== 1'b0) begin n_fail++;
            $display("FAIL word_load_err got %b want 0", er); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er; int lat;
        xfer(32'h20, 32'h11223344, 1'b1, 2'b10, rd, er, lat);
        xfer(32'h21, 32'h000000AA, 1'b1, 2'b00, rd, er, lat);
        xfer(32'h20, 32'h0, 1'b0, 2'b10, rd, er, lat);
        n_tests++; if (rd !== 32'h1122AA44) begin n_fail++;
            $display("FAIL byte_merge got %h want 1122aa44", rd); end
        xfer(32'h23, 32'h0, 1'b0, 2'b00, rd, er, lat);
        n_tests++; if (rd !== 32'h00000011) begin n_fail++;
            $display("FAIL byte_load3 got %h want 00000011", rd); end
        xfer(32'h21, 32'h0, 1'b0, 2'b00, rd, er, lat);
        n_tests++; if (rd !== 32'h000000AA) begin n_fail++;
            $display("FAIL byte_load1 got %h want 000000aa", rd); end
        xfer(32'h22, 32'h0, 1'b0, 2'b01, rd, er, lat);
        n_tests++; if (rd !== 32'h00001122) begin n_fail++;
            $display("FAIL half_load_hi got %h want 00001122", rd); end
    endtask

    task automatic test_half_wrap();
        logic [31:0] rd; logic er; int lat;
        xfer(32'h000, 32'h12345678, 1'b1, 2'b10, rd, er, lat);
        xfer(32'h402, 32'h0000BEEF, 1'b1, 2'b01, rd, er, lat);
        xfer(32'h000, 32'h0, 1'b0, 2'b10, rd, er, lat);
        n_tests++; if (rd !== 32'hBEEF5678) begin n_fail++;
            $display("FAIL half_wrap_word got %h want beef5678", rd); end
        xfer(32'h002, 32'h0, 1'b0, 2'b01, rd, er, lat);
        n_tests++; if (rd !== 32'h0000BEEF) begin n_fail++;
            $display("FAIL half_wrap_half got %h want 0000beef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; bit seen;
        @(negedge clock);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h10;
        bus.req_write  = 1'b0;
        bus.req_type   = 2'b10;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (bus.resp_valid) begin seen = 1'b1; break; end
        end
        n_tests++; if (!seen) begin n_fail++;
            $display("FAIL bp_resp_timeout resp_valid never rose"); end
        // Competing store held while the response is stalled.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h14;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_write = 1'b1;
        bus.req_type  = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            n_tests++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF ||
                bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d valid %b rdata %h ready %b want 1 deadbeef 0",
                         k, bus.resp_valid, bus.resp_rdata, bus.req_ready);
            end
        end
        @(negedge clock);
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        n_tests++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++;
            $display("FAIL bp_release valid %b ready %b want 0 1", bus.resp_valid,
                     bus.req_ready); end
        @(posedge clock);
        #1;
        n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++;
            $display("FAIL bp_next_accept ready %b want 0", bus.req_ready); end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.req_ready; i++) begin
            @(posedge clock);
            #1;
        end
        xfer(32'h14, 32'h0, 1'b0, 2'b10, rd, er, lat);
        n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++;
            $display("FAIL bp_queued_store got %h want cafef00d", rd); end
    endtask

    task automatic test_back_to_back();
        int acc [2];
        int n_acc;
        logic rdy;
        n_acc = 0;
        @(negedge clock);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h10;
        bus.req_write  = 1'b0;
        bus.req_type   = 2'b10;
        for (int c = 0; c < 30 && n_acc < 2; c++) begin
            rdy = bus.req_ready;
            @(posedge clock);
            if (rdy) begin acc[n_acc] = c; n_acc++; end
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        n_tests++; if (n_acc != 2 || (acc[1] - acc[0]) != 5) begin n_fail++;
            $display("FAIL b2b_period accepts %0d spacing %0d want 2 spacing 5", n_acc,
                     acc[1] - acc[0]); end
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clock);
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat;
        xfer(32'h30, 32'h0, 1'b1, 2'b10, rd, er, lat);
        xfer(32'h10, 32'h0, 1'b0, 2'b10, rd, er, lat);
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'h55;
        bus.req_write  = 1'b1;
        bus.req_type   = 2'b00;
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
            bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs ready %b valid %b rdata %h err %b want 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        xfer(32'h30, 32'h0, 1'b0, 2'b10, rd, er, lat);
        n_tests++; if (rd !== 32'h0) begin n_fail++;
            $display("FAIL rst_mid_dropped got %h want 00000000", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
        xfer(32'h40, 32'h01020304, 1'b1, 2'b10, rd, er, lat);
        xfer(32'h41, 32'h99887766, 1'b1, 2'b10, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
        n_tests++; if (er !== 1'b1 || lat != 4) begin n_fail++;
            $display("FAIL misalign_err got %b lat %0d want 1 lat 4", er, lat); end
        xfer(32'h40, 32'h0, 1'b0, 2'b10, rd, er, lat);
        n_tests++; if (rd !== 32'h01020304) begin n_fail++;
            $display("FAIL misalign_mem got %h want 01020304", rd); end
`else
        n_tests++; if (er !== 1'b0) begin n_fail++;
            $display("FAIL misalign_err got %b want 0", er); end
        xfer(32'h40, 32'h0, 1'b0, 2'b10, rd, er, lat);
        n_tests++; if (rd !== 32'h99887766) begin n_fail++;
            $display("FAIL misalign_mem got %h want 99887766", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_half_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
